// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if
// Bundles every non-clock/reset signal of alu_result_checker.
//   Launch/result side : in_valid, sum, actual_sum, clear
//   Result FIFO head   : res_valid, res_ready, res_sum, res_match
//   Status             : pass_cnt, fail_cnt, err_sticky, ovf_sticky,
//                        first_bad_sum, first_bad_ref, halted
// Modports:
//   master : environment side (drives launches, results, clear, res_ready)
//   slave  : checker side
interface alu_result_checker_if #(
  parameter int WIDTH = 33,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] actual_sum;
  logic             clear;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_match;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err_sticky;
  logic             ovf_sticky;
  logic [WIDTH-1:0] first_bad_sum;
  logic [WIDTH-1:0] first_bad_ref;
  logic             halted;

  modport master (
    output in_valid, sum, actual_sum, clear, res_ready,
    input  res_valid, res_sum, res_match, pass_cnt, fail_cnt,
           err_sticky, ovf_sticky, first_bad_sum, first_bad_ref, halted
  );

  modport slave (
    input  in_valid, sum, actual_sum, clear, res_ready,
    output res_valid, res_sum, res_match, pass_cnt, fail_cnt,
           err_sticky, ovf_sticky, first_bad_sum, first_bad_ref, halted
  );
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker
// Tracks operations launched into the TCAM adder with a valid delay line
// matched to the adder latency. When a tag lands, the TCAM result (sum) is
// compared against the reference (actual_sum); the outcome is pushed into a
// 2-entry result FIFO and scored in saturating pass/fail counters. The first
// mismatch is captured for debug. With STOP_ON_ERR=1 a mismatch halts the
// acceptance of new launches until clear or reset.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : alu_result_checker_if.slave (launch/results, FIFO head, status)
module alu_result_checker #(
  parameter int WIDTH       = 33,
  parameter int LATENCY     = 4,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input logic                 clk,
  input logic                 rst,
  alu_result_checker_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  localparam int EW = WIDTH + 1;  // FIFO entry: {sum, match}

  state_t                 state_q, state_d;
  logic [LATENCY-1:0]     dl_q, dl_d;
  logic [1:0][EW-1:0]     fifo_q, fifo_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]       pass_q, pass_d;
  logic [CNT_W-1:0]       fail_q, fail_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [WIDTH-1:0]       fbs_q, fbs_d;
  logic [WIDTH-1:0]       fbr_q, fbr_d;

  logic accept;
  logic land;
  logic match;
  logic count_en;
  logic bad;
  logic pop;
  logic drop;

  // New tags are refused while halted; in-flight ones keep moving.
  assign accept   = bus.in_valid && (state_q != ST_HALT);
  assign land     = dl_q[LATENCY-1];
  // A land coinciding with clear is still queued but not scored.
  assign count_en = land && !bus.clear;
  assign bad      = count_en && !match;

  assign dl_d[0] = accept;
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_dl
      assign dl_d[gi] = dl_q[gi-1];
    end
  endgenerate

  // An X/Z on either side makes the equality unknown, which does not take
  // the if-branch, so only a clean bit-exact equality scores as a match.
  always_comb begin
    match = 1'b0;
    if (bus.sum == bus.actual_sum) begin
      match = 1'b1;
    end
  end

  // Result FIFO: slot 0 is the registered head. The pop is applied first so
  // that a push into a full FIFO that is popping in the same cycle fits.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    drop   = 1'b0;
    pop    = (cnt_q != 2'd0) && bus.res_ready;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = '0;
      cnt_d     = cnt_q - 2'd1;
    end
    if (land) begin
      if (cnt_d == 2'd2) begin
        drop = 1'b1;
      end else begin
        fifo_d[cnt_d[0]] = {bus.sum, match};
        cnt_d            = cnt_d + 2'd1;
      end
    end
  end

  // Counters, sticky flags and first-mismatch capture.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    ovf_d  = ovf_q;
    fbs_d  = fbs_q;
    fbr_d  = fbr_q;
    if (bus.clear) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
      fbs_d  = '0;
      fbr_d  = '0;
    end else begin
      if (count_en && match && (pass_q != {CNT_W{1'b1}})) begin
        pass_d = pass_q + CNT_W'(1);
      end
      if (bad) begin
        if (fail_q != {CNT_W{1'b1}}) begin
          fail_d = fail_q + CNT_W'(1);
        end
        if (!err_q) begin
          fbs_d = bus.sum;
          fbr_d = bus.actual_sum;
        end
        err_d = 1'b1;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // IDLE also leaves for RUN when tags are still in flight, which happens
  // after clear pulls the FSM out of HALT with lands pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((STOP_ON_ERR != 0) && bad) begin
          state_d = ST_HALT;
        end else if (bus.in_valid || (dl_q != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((STOP_ON_ERR != 0) && bad) begin
          state_d = ST_HALT;
        end else if ((dl_q == '0) && !bus.in_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dl_q    <= '0;
      fifo_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      fbs_q   <= '0;
      fbr_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      fifo_q  <= fifo_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      fbs_q   <= fbs_d;
      fbr_q   <= fbr_d;
    end
  end

  assign bus.res_valid     = (cnt_q != 2'd0);
  assign bus.res_sum       = fifo_q[0][EW-1:1];
  assign bus.res_match     = fifo_q[0][0];
  assign bus.pass_cnt      = pass_q;
  assign bus.fail_cnt      = fail_q;
  assign bus.err_sticky    = err_q;
  assign bus.ovf_sticky    = ovf_q;
  assign bus.first_bad_sum = fbs_q;
  assign bus.first_bad_ref = fbr_q;
  assign bus.halted        = (state_q == ST_HALT);
endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Downstream consumer of the TCAM-based 32-bit adder. It tracks launched operations with a valid delay line matched to the adder latency. When each operation lands, it samples the TCAM-path result (sum) and the behavioural reference result (actual_sum) and compares them. Results go into a 2-entry output FIFO with a valid/ready handshake; the block also keeps pass/fail counters and captures the first mismatch for debug.

Parameters:
WIDTH, 33, result width (32-bit sum plus carry-out)
LATENCY, 4, cycles from in_valid to both results being valid at the inputs; legal range 1..8
CNT_W, 16, width of pass/fail counters
STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  operands launched into the adder this cycle
sum  input  WIDTH  TCAM-path result
actual_sum  input  WIDTH  behavioural reference result
clear  input  1  synchronous clear of counters, sticky flags, capture regs and HALT
res_valid  output  1  FIFO head valid
res_ready  input  1  consumer accepts FIFO head
res_sum  output  WIDTH  FIFO head result (the TCAM value)
res_match  output  1  FIFO head compare outcome
pass_cnt  output  CNT_W  matching results, saturating
fail_cnt  output  CNT_W  mismatching results, saturating
err_sticky  output  1  set on any mismatch
ovf_sticky  output  1  set when a landing result is dropped because the FIFO is full
first_bad_sum  output  WIDTH  sum of the first mismatch
first_bad_ref  output  WIDTH  actual_sum of the first mismatch
halted  output  1  state is HALT

Behaviour:
- Reset (rst==0 at posedge):
  - Delay line, FIFO, counters, sticky flags and capture regs all clear to 0.
  - State goes to IDLE; all outputs are 0.
  - A reset mid-operation discards every in-flight tag.
- Delay line: a LATENCY-deep shift of in_valid. The tag at stage LATENCY-1 is "land".
- On land:
  - Compare sum against actual_sum over the full WIDTH bits, including the carry bit.
  - match = 1 only if the values are equal and neither contains X/Z.
  - The compare is purely combinational on the landing cycle; no extra input registering.
- FSM states:
  - IDLE: no tags in flight. Goes to RUN when in_valid=1.
  - RUN: tags in flight. Goes back to IDLE when the delay line is empty and in_valid=0.
  - RUN goes to HALT on a mismatch land when STOP_ON_ERR=1.
  - HALT: in_valid is ignored (no new tags enter). In-flight tags still land and are counted. Only clear or rst leaves HALT, returning to IDLE.
- Counters: the landing cycle increments pass_cnt or fail_cnt. Both saturate at all-ones with no wrap.
- First-mismatch capture:
  - On a mismatch land while err_sticky==0, latch first_bad_sum and first_bad_ref.
  - err_sticky is set in the same cycle, so the captured values and the flag become visible together on the next cycle.
  - Later mismatches do not overwrite the capture.
- FIFO: 2 entries, each holding {sum, match}.
  - Push on land; pop when res_valid && res_ready.
  - Push and pop in the same cycle with count==2: legal; the pop frees space first, so count stays 2 and no overflow.
  - Push while count==2 and no pop: the entry is dropped, ovf_sticky is set, and counters still update.
  - The output is the registered head. An entry pushed into an empty FIFO appears on res_valid on the next cycle.
  - res_valid must not drop while res_ready==0.
- clear:
  - Zeroes the counters, sticky flags and capture regs, and forces HALT to IDLE.
  - Does not flush the delay line or the FIFO.
  - A land in the same cycle as clear is ignored for counting; it is still pushed to the FIFO.
- Overall latency: in_valid to res_valid is LATENCY+1 cycles.

Test Plan:
- Match path: LATENCY=4; pulse in_valid at cycle 0; drive sum=actual_sum=33'h0_0000_0003 at cycle 4 -> res_valid=1 at cycle 5, res_sum=3, res_match=1, pass_cnt=1, fail_cnt=0.
- Mismatch capture: two lands at cycles 4 and 5 with sum=33'h1_0000_0000/actual_sum=33'h0_FFFF_FFFF, then sum=5/actual_sum=6 -> fail_cnt=2, err_sticky=1, first_bad_sum=33'h1_0000_0000, first_bad_ref=33'h0_FFFF_FFFF.
- Backpressure: res_ready=0; in_valid high for 3 consecutive cycles, all matching -> FIFO holds 2 entries, third land sets ovf_sticky=1, pass_cnt=3; then res_ready=1 -> exactly 2 pops, in order.
- STOP_ON_ERR=1: mismatch lands while 2 tags are still in flight -> halted=1, both in-flight tags still counted, in_valid pulses during HALT produce no lands; clear -> halted=0, counters=0.
- X handling: actual_sum carries X on bit 7 at a land -> res_match=0, fail_cnt increments.
- Reset mid-flight: assert rst=0 with 3 tags in the delay line -> no res_valid afterwards, all outputs 0, state IDLE.
